// File: rtl/minimal_gate_arbiter.sv
// minimal_gate_arbiter
//   Shares one single-bit gate (gate_i -> gate_o, GATE_LAT cycles) between
//   NUM_REQ requesters. Round-robin, one transaction in flight at a time.
//   Ports:
//     clk, rst         clock, async active-high reset
//     req[NUM_REQ]     request levels
//     din[NUM_REQ]     per-requester data bit for the gate
//     ack[NUM_REQ]     one-hot, one-cycle completion pulse
//     dout             gate result (valid with ack, held otherwise)
//     grant_idx        current/last winner
//     busy             transaction in flight (WAIT or RESP)
//     gate_i / gate_o  shared gate input / output

// Per-requester ack decode.
module minimal_gate_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             resp,
  input  logic [IDX_W-1:0] grant_idx,
  output logic             ack
);
  assign ack = resp && (grant_idx == IDX_W'(LANE));
endmodule

module minimal_gate_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GATE_LAT = 1,
  parameter int IDX_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] ack,
  output logic               dout,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               gate_i,
  input  logic               gate_o
);
  localparam int CNT_W = (GATE_LAT < 1) ? 1 : $clog2(GATE_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] win;

  // Round-robin pick: first set req bit after the last winner.
  always_comb begin
    int   idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: grant capture, latency counter, result sample, priority update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_i    <= 1'b0;
      dout      <= 1'b0;
      grant_idx <= '0;
      cnt       <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (|req) begin
          gate_i    <= din[win];
          grant_idx <= win;
          cnt       <= CNT_W'(GATE_LAT - 1);
        end
        WAIT: begin
          // gate_o is only trusted at the final WAIT edge.
          if (cnt == '0) dout <= gate_o;
          else           cnt  <= cnt - 1'b1;
        end
        RESP: last <= grant_idx;
        default: ;
      endcase
    end
  end

  assign busy = (state == WAIT) || (state == RESP);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    minimal_gate_arbiter_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .resp      (state == RESP),
      .grant_idx (grant_idx),
      .ack       (ack[g])
    );
  end
endmodule

// File: tb/tb_minimal_gate_arbiter.sv
module tb_minimal_gate_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u1: GATE_LAT=1, combinational gate model with optional inversion
  logic [3:0] req1 = '0, din1 = '0, ack1;
  logic       dout1, busy1, gate_i1, gate_o1, inv1 = 1'b0;
  logic [1:0] gidx1;
  assign gate_o1 = gate_i1 ^ inv1;

  // u3: GATE_LAT=3, gate output driven directly by the bench
  logic [3:0] req3 = '0, din3 = '0, ack3;
  logic       dout3, busy3, gate_i3, gate_o3 = 1'b0;
  logic [1:0] gidx3;

  minimal_gate_arbiter #(.NUM_REQ(4), .GATE_LAT(1), .IDX_W(2)) u1 (
    .clk(clk), .rst(rst), .req(req1), .din(din1), .ack(ack1), .dout(dout1),
    .grant_idx(gidx1), .busy(busy1), .gate_i(gate_i1), .gate_o(gate_o1));

  minimal_gate_arbiter #(.NUM_REQ(4), .GATE_LAT(3), .IDX_W(2)) u3 (
    .clk(clk), .rst(rst), .req(req3), .din(din3), .ack(ack3), .dout(dout3),
    .grant_idx(gidx3), .busy(busy3), .gate_i(gate_i3), .gate_o(gate_o3));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req1 = '0; din1 = '0; req3 = '0; din3 = '0; inv1 = 1'b0; gate_o3 = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  // Cycles from the current cycle until ack1 rises (bounded).
  task automatic wait_ack1(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack1 != '0) begin n = i; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_ack3(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack3 != '0) begin n = i; ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    checks++;
    if ({ack1, dout1, gidx1, busy1, gate_i1} !== 9'b0) begin
      errors++; $display("FAIL reset_u1 got=%b exp=%b", {ack1, dout1, gidx1, busy1, gate_i1}, 9'b0);
    end
    checks++;
    if ({ack3, dout3, gidx3, busy3, gate_i3} !== 9'b0) begin
      errors++; $display("FAIL reset_u3 got=%b exp=%b", {ack3, dout3, gidx3, busy3, gate_i3}, 9'b0);
    end
    tick(); rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req1 = 4'b0001; din1 = 4'b0001; inv1 = 1'b0;   // cycle 0
    tick();                                          // cycle 1
    checks++;
    if ({gate_i1, busy1, ack1} !== 6'b1_1_0000) begin
      errors++; $display("FAIL single_c1 got=%b exp=%b", {gate_i1, busy1, ack1}, 6'b110000);
    end
    tick();                                          // cycle 2
    checks++;
    if ({ack1, dout1, busy1} !== 6'b0001_1_1) begin
      errors++; $display("FAIL single_c2 got=%b exp=%b", {ack1, dout1, busy1}, 6'b000111);
    end
    req1 = '0;
    tick();                                          // cycle 3
    checks++;
    if ({busy1, ack1} !== 5'b0) begin
      errors++; $display("FAIL single_c3 got=%b exp=%b", {busy1, ack1}, 5'b0);
    end
  endtask

  task automatic test_all_req();
    int n; bit ok;
    do_reset();
    req1 = 4'b1111; din1 = 4'b1010; inv1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack1(n, ok);
      checks++;
      if (!ok || ack1 !== 4'(1 << k) || n != (k == 0 ? 2 : 3) || dout1 !== ~din1[k]) begin
        errors++;
        $display("FAIL all_req_%0d got ack=%b n=%0d dout=%b exp ack=%b n=%0d dout=%b",
                 k, ack1, n, dout1, 4'(1 << k), (k == 0 ? 2 : 3), ~din1[k]);
      end
      req1[k] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int n; bit ok; int exp;
    do_reset();
    req1 = 4'b0101; din1 = 4'b0001; inv1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp = (k % 2 == 0) ? 0 : 2;
      wait_ack1(n, ok);
      checks++;
      if (!ok || ack1 !== 4'(1 << exp) || gidx1 !== 2'(exp) || n != (k == 0 ? 2 : 3)) begin
        errors++;
        $display("FAIL fair_%0d got ack=%b idx=%0d n=%0d exp ack=%b idx=%0d n=%0d",
                 k, ack1, gidx1, n, 4'(1 << exp), exp, (k == 0 ? 2 : 3));
      end
    end
    req1 = '0; tick();
  endtask

  // Latency 3: gate_o is value a in cycles 1-2 and b in cycle 3; dout must be b.
  task automatic lat3_txn(input logic a, input logic b, input string name);
    req3 = 4'b0100; din3 = 4'b0100;                 // cycle 0
    tick(); gate_o3 = a;                             // cycle 1
    checks++;
    if ({busy3, gate_i3, gidx3} !== 4'b1_1_10) begin
      errors++; $display("FAIL %s_grant got=%b exp=%b", name, {busy3, gate_i3, gidx3}, 4'b1110);
    end
    tick();                                          // cycle 2
    tick(); gate_o3 = b;                             // cycle 3
    checks++;
    if (ack3 !== 4'b0) begin
      errors++; $display("FAIL %s_early_ack got=%b exp=0000", name, ack3);
    end
    tick();                                          // cycle 4
    checks++;
    if (ack3 !== 4'b0100 || dout3 !== b) begin
      errors++; $display("FAIL %s_ack got ack=%b dout=%b exp ack=0100 dout=%b", name, ack3, dout3, b);
    end
    req3 = '0; tick();
  endtask

  task automatic test_latency();
    do_reset();
    lat3_txn(1'b1, 1'b0, "lat3_a");
    lat3_txn(1'b0, 1'b1, "lat3_b");
  endtask

  // Runs right after test_latency: last=2, dout3=1.
  task automatic test_reset_mid_wait();
    int n; bit ok;
    req3 = 4'b1000; din3 = 4'b1000; gate_o3 = 1'b1; // cycle 0
    tick();                                          // cycle 1
    checks++;
    if ({busy3, gate_i3, gidx3} !== 4'b1_1_11) begin
      errors++; $display("FAIL rstmid_grant got=%b exp=%b", {busy3, gate_i3, gidx3}, 4'b1111);
    end
    tick();                                          // cycle 2
    rst = 1'b1; req3 = '0; #1;
    checks++;
    if ({ack3, dout3, gidx3, busy3, gate_i3} !== 9'b0) begin
      errors++; $display("FAIL rstmid_async got=%b exp=%b", {ack3, dout3, gidx3, busy3, gate_i3}, 9'b0);
    end
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ack3 !== 4'b0 || busy3 !== 1'b0) begin
        errors++; $display("FAIL rstmid_noack_%0d got ack=%b busy=%b exp 0000 0", i, ack3, busy3);
      end
    end
    req3 = 4'b1001; din3 = 4'b0000;
    wait_ack3(n, ok);
    checks++;
    if (!ok || ack3 !== 4'b0001 || n != 4) begin
      errors++; $display("FAIL rstmid_prio got ack=%b n=%0d exp ack=0001 n=4", ack3, n);
    end
    req3 = '0; tick();
  endtask

  task automatic test_idle_stable();
    int n; bit ok; int bad;
    do_reset();
    req1 = 4'b0010; din1 = 4'b0010; inv1 = 1'b0;
    wait_ack1(n, ok);
    checks++;
    if (!ok || ack1 !== 4'b0010 || dout1 !== 1'b1) begin
      errors++; $display("FAIL idle_txn got ack=%b dout=%b exp 0010 1", ack1, dout1);
    end
    req1 = '0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({busy1, ack1, gate_i1, dout1, gidx1} !== 9'b0_0000_1_1_01) begin
        errors++;
        if (bad++ < 3)
          $display("FAIL idle_%0d got=%b exp=%b", i, {busy1, ack1, gate_i1, dout1, gidx1}, 9'b000001101);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_latency();
    test_reset_mid_wait();
    test_idle_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
